// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle between the controlling logic and serial_adder.
// The master drives the request, the slave (the adder) returns result, flags and status.
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, cin, sub,
        input  sum, cout, overflow, zero, busy, done
    );

    modport slave (
        input  start, a, b, cin, sub,
        output sum, cout, overflow, zero, busy, done
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder cell plus a carry flop, LSB first,
// one bit per clock, with registered sum/carry/overflow/zero and start/busy/done.
module serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    serial_adder_if.slave        bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] r_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    logic             s_d;
    logic             c_d;
    logic [WIDTH-1:0] r_d;
    logic             last_d;

    // The single full-adder cell working on the current LSBs.
    always_comb begin
        s_d    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        c_d    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        r_d    = {s_d, r_q[WIDTH-1:1]};
        last_d = (cnt_q == LAST);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b ^ {WIDTH{bus.sub}};
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
                        r_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= c_d;
                    r_q     <= r_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_d) begin
                        // carry_q here is still the carry into the MSB.
                        sum_q   <= r_d;
                        cout_q  <= c_d;
                        ovf_q   <= carry_q ^ c_d;
                        zero_q  <= (r_d == '0);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
